// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24C02-class EEPROM: byte/page writes, random and sequential reads.
// SCL/SDA are oversampled on sys_clk; sda_oe_o pulls the open-drain SDA line low.
module i2c_eeprom_slave #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned PAGE_SIZE = 8
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       busy_o,
  output logic       wr_strobe_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] mem00_data_o
);

  localparam logic [7:0] LastAddr = 8'(MEM_DEPTH - 1);
  localparam logic [7:0] PageMask = 8'(PAGE_SIZE - 1);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckDev, StWordAddr, StAckWord, StWrData, StAckWr, StRdData, StRdAck
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_hist_q, sda_hist_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  mem_q [MEM_DEPTH];
  logic        mem_we;
  logic [7:0]  rd_byte;
  logic [2:0]  bit_idx;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  // Sync flops reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      strobe_q   <= strobe_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= shift_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    rd_byte   = mem_q[ptr_q];
    bit_idx   = 3'(4'd7 - cnt_q);
    if (start_det) begin
      state_d  = StDevAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StDevAddr, StWordAddr, StWrData: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == StDevAddr) begin
                rw_d    = sda_s;
                state_d = (shift_d[7:1] == DEV_ADDR) ? StAckDev : StIdle;
              end else begin
                state_d = (state_q == StWordAddr) ? StAckWord : StAckWr;
              end
            end
          end
        end
        // First fall asserts the ACK, second fall ends it and performs the phase action.
        StAckDev, StAckWord, StAckWr: begin
          if (scl_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) begin
              if (state_q == StAckDev) begin
                if (rw_q) begin
                  state_d  = StRdData;
                  sda_oe_d = ~rd_byte[7];
                  cnt_d    = 4'd1;
                end else begin
                  state_d = StWordAddr;
                end
              end else if (state_q == StAckWord) begin
                ptr_d   = 8'({24'd0, shift_q} % MEM_DEPTH);
                state_d = StWrData;
              end else begin
                mem_we    = 1'b1;
                strobe_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_q;
                ptr_d     = (ptr_q & ~PageMask) | ((ptr_q + 8'd1) & PageMask);
                state_d   = StWrData;
              end
            end
          end
        end
        StRdData: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = (ptr_q == LastAddr) ? 8'd0 : ptr_q + 8'd1;
              cnt_d    = '0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d = ~rd_byte[bit_idx];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            cnt_d   = '0;
            state_d = sda_s ? StIdle : StRdData;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe_o     = sda_oe_q;
    busy_o       = !(state_q inside {StIdle, StDevAddr});
    wr_strobe_o  = strobe_q;
    wr_addr_o    = wr_addr_q;
    wr_data_o    = wr_data_q;
    mem00_data_o = mem_q[0];
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged I2C master with a byte-array model of the EEPROM.
// Expected writes and read bytes are queued from the model and compared as the DUT produces them.
module tb_i2c_eeprom_slave;

  localparam int Q = 100;  // quarter SCL period in time units; sys_clk period is 10

  logic clk = 1'b0;
  logic rst, scl_m, sda_m;
  wire  sda_line;
  logic sda_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data, mem00;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  tb_mem [256];
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  got_rd_q [$];
  logic watch = 1'b0;
  logic saw_drive, saw_busy;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_eeprom_slave dut (
    .sys_clk_i    (clk),
    .rst_i        (rst),
    .scl_i        (scl_m),
    .sda_i        (sda_line),
    .sda_oe_o     (sda_oe),
    .busy_o       (busy),
    .wr_strobe_o  (wr_strobe),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .mem00_data_o (mem00)
  );

  // Write scoreboard: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (wr_strobe) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %h data %h, required no write", wr_addr, wr_data);
      end else begin
        exp = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          n_fail++;
          $display("FAIL wr_commit: got addr %h data %h, required addr %h data %h",
                   wr_addr, wr_data, exp[15:8], exp[7:0]);
        end
      end
    end
    if (watch) begin
      if (sda_oe) saw_drive = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
  end

  task automatic bus_idle();
    sda_m = 1'b1; scl_m = 1'b1; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_n);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_n);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_n);
  endtask

  // Page write of n bytes first, first+1, ...; model applies the in-page address wrap.
  task automatic write_bytes(input logic [7:0] addr, input int n, input logic [7:0] first,
                             output int nacks);
    logic ack_n;
    logic [7:0] a;
    nacks = 0;
    a = addr;
    i2c_start();
    send_byte(8'hA0, ack_n); nacks += int'(ack_n);
    send_byte(addr, ack_n);  nacks += int'(ack_n);
    for (int k = 0; k < n; k++) begin
      exp_wr_q.push_back({a, first + 8'(k)});
      tb_mem[a] = first + 8'(k);
      send_byte(first + 8'(k), ack_n); nacks += int'(ack_n);
      a = (a & 8'hF8) | ((a + 8'd1) & 8'h07);
    end
    i2c_stop();
    #(4*Q);
  endtask

  // Random read then sequential read of n bytes; last byte NACKed.
  task automatic read_bytes(input logic [7:0] addr, input int n, output int nacks,
                            output logic oe_after_nack);
    logic ack_n;
    logic [7:0] a, d;
    nacks = 0;
    a = addr;
    i2c_start();
    send_byte(8'hA0, ack_n); nacks += int'(ack_n);
    send_byte(addr, ack_n);  nacks += int'(ack_n);
    i2c_rstart();
    send_byte(8'hA1, ack_n); nacks += int'(ack_n);
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(tb_mem[a]);
      a = a + 8'd1;
      recv_byte(d, (k == n - 1));
      got_rd_q.push_back(d);
    end
    oe_after_nack = sda_oe;
    i2c_stop();
    #(4*Q);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    #20;
    n_checks++;
    if ({sda_oe, busy, wr_strobe} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got oe/busy/strobe %b, required 000", {sda_oe, busy, wr_strobe});
    end
    n_checks++;
    if ({wr_addr, wr_data, mem00} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 000000", {wr_addr, wr_data, mem00});
    end
    rst = 1'b0;
    #Q;
  endtask

  task automatic test_byte_write();
    logic a0, a1, a2;
    i2c_start();
    send_byte(8'hA0, a0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bw_busy: got %b, required 1", busy);
    end
    send_byte(8'h00, a1);
    exp_wr_q.push_back(16'h005A);
    tb_mem[0] = 8'h5A;
    send_byte(8'h5A, a2);
    i2c_stop();
    #(4*Q);
    n_checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      n_fail++;
      $display("FAIL bw_acks: got %b, required 000", {a0, a1, a2});
    end
    n_checks++;
    if (mem00 !== 8'h5A || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bw_mem00: got mem00 %h busy %b, required 5a busy 0", mem00, busy);
    end
    n_checks++;
    if (exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL bw_commits: got %0d pending, required 0", exp_wr_q.size());
    end
  endtask

  task automatic check_reads(input string name, input int n);
    logic [7:0] g, e;
    n_checks++;
    if (got_rd_q.size() != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got_rd_q.size(), n);
    end
    while (got_rd_q.size() != 0 && exp_rd_q.size() != 0) begin
      g = got_rd_q.pop_front();
      e = exp_rd_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s_data: got %h, required %h", name, g, e);
      end
    end
  endtask

  task automatic test_random_read();
    int nw, nr;
    logic oe;
    write_bytes(8'h10, 1, 8'h3C, nw);
    read_bytes(8'h10, 1, nr, oe);
    n_checks++;
    if (nw != 0 || nr != 0 || oe !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_ack: got nacks %0d/%0d oe %b, required 0/0 oe 0", nw, nr, oe);
    end
    check_reads("rr", 1);
  endtask

  task automatic test_page_wrap();
    int nw, nr;
    logic oe;
    write_bytes(8'h06, 9, 8'h11, nw);
    n_checks++;
    if (nw != 0 || exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL pw_write: got nacks %0d pending %0d, required 0 0", nw, exp_wr_q.size());
    end
    read_bytes(8'h06, 3, nr, oe);
    check_reads("pw", 3);
  endtask

  task automatic test_back_to_back_seq_wrap();
    int nw, nr;
    logic oe;
    write_bytes(8'hFE, 2, 8'hA5, nw);
    read_bytes(8'hFE, 3, nr, oe);
    n_checks++;
    if (nw != 0 || nr != 0 || oe !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_ack: got nacks %0d/%0d oe %b, required 0/0 oe 0", nw, nr, oe);
    end
    check_reads("sw", 3);
  endtask

  task automatic test_mismatch();
    logic a0, a1, a2;
    saw_drive = 1'b0;
    saw_busy  = 1'b0;
    watch     = 1'b1;
    i2c_start();
    send_byte(8'hA2, a0);
    send_byte(8'h00, a1);
    send_byte(8'h77, a2);
    i2c_stop();
    #(4*Q);
    watch = 1'b0;
    n_checks++;
    if (a0 !== 1'b1 || saw_drive !== 1'b0 || saw_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_ignore: got ack_n %b drive %b busy %b, required 1 0 0",
               a0, saw_drive, saw_busy);
    end
  endtask

  task automatic test_abort();
    logic ack_n, b;
    int nw;
    i2c_start();
    send_byte(8'hA0, ack_n);
    send_byte(8'h08, ack_n);
    i2c_rstart();
    send_byte(8'hA1, ack_n);
    for (int i = 0; i < 3; i++) recv_bit(b);
    sda_m = 1'b1; #Q;
    // mem[0x08] is 0x00, so the slave is pulling SDA low here
    n_checks++;
    if (sda_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL ab_drive: got %b, required 1", sda_oe);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ab_release: got oe %b busy %b, required 0 0", sda_oe, busy);
    end
    #19;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    bus_idle();
    #(2*Q);
    n_checks++;
    if (mem00 !== 8'h00) begin
      n_fail++;
      $display("FAIL ab_memclr: got %h, required 00", mem00);
    end
    write_bytes(8'h00, 1, 8'h5A, nw);
    n_checks++;
    if (nw != 0 || mem00 !== 8'h5A || exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL ab_rewrite: got nacks %0d mem00 %h pending %0d, required 0 5a 0",
               nw, mem00, exp_wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_page_wrap();
    test_back_to_back_seq_wrap();
    test_mismatch();
    test_abort();
    #(4*Q);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
